multdiv_issue_ctrl: RTL and testbench

//  Upstream sequencer for the iterative multdiv unit in the execute stage. Takes one MUL/DIV

---
 rtl/multdiv_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - issue-side sequencer for the iterative multdiv unit
// Accepts one op, pulses start, waits for RDY (with stale mask and watchdog), holds result for writeback.
module multdiv_issue_ctrl #(
    parameter int TAG_W    = 5,
    parameter int TIMEOUT  = 64,
    parameter int RDY_MASK = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_div,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [31:0]      md_operandA,
    output logic [31:0]      md_operandB,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    input  logic [31:0]      md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_exception,
    output logic             out_timeout,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        opa_q, opa_d;
    logic [31:0]        opb_q, opb_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               is_div_q, is_div_d;
    logic [31:0]        res_q, res_d;
    logic               exc_q, exc_d;
    logic               to_q, to_d;
    logic [TAG_W-1:0]   otag_q, otag_d;

    logic accept;
    logic rdy_hit;
    logic to_hit;

    assign accept  = in_valid && in_ready;
    // RDY seen in the first RDY_MASK busy cycles belongs to a previous op
    assign rdy_hit = (cnt_q >= CNT_W'(RDY_MASK)) && md_resultRDY;
    assign to_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            tag_q    <= '0;
            is_div_q <= 1'b0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            to_q     <= 1'b0;
            otag_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            tag_q    <= tag_d;
            is_div_q <= is_div_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            to_q     <= to_d;
            otag_q   <= otag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: state_d = S_BUSY;
            S_BUSY:  if (rdy_hit || to_hit) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = accept ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        tag_d    = tag_q;
        is_div_d = is_div_q;
        res_d    = res_q;
        exc_d    = exc_q;
        to_d     = to_q;
        otag_d   = otag_q;
        if (accept) begin
            opa_d    = in_a;
            opb_d    = in_b;
            tag_d    = in_tag;
            is_div_d = in_is_div;
        end
        if (state_q == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_BUSY) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (!flush) begin
                if (rdy_hit) begin
                    res_d  = md_result;
                    exc_d  = md_exception;
                    to_d   = 1'b0;
                    otag_d = tag_q;
                end else if (to_hit) begin
                    res_d  = '0;
                    exc_d  = 1'b1;
                    to_d   = 1'b1;
                    otag_d = tag_q;
                end
            end
        end
    end

    always_comb begin
        in_ready      = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
        md_ctrl_MULT  = (state_q == S_START) && !is_div_q;
        md_ctrl_DIV   = (state_q == S_START) && is_div_q;
        busy          = (state_q != S_IDLE);
        out_valid     = (state_q == S_DONE);
        md_operandA   = opa_q;
        md_operandB   = opb_q;
        out_result    = res_q;
        out_exception = exc_q;
        out_timeout   = to_q;
        out_tag       = otag_q;
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - self-checking bench for multdiv_issue_ctrl
// Table of ops plus hand sequences for hold, back-to-back, flush, timeout and reset.
module tb_multdiv_issue_ctrl;
    localparam int TAG_W    = 5;
    localparam int TIMEOUT  = 16;
    localparam int RDY_MASK = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid, in_ready, in_is_div;
    logic [31:0]      in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic [31:0]      md_operandA, md_operandB;
    logic             md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0]      md_result = '0;
    logic             md_exception = 1'b0;
    logic             md_resultRDY = 1'b0;
    logic             out_valid, out_ready;
    logic [31:0]      out_result;
    logic             out_exception, out_timeout;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    multdiv_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .RDY_MASK(RDY_MASK)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_div(in_is_div),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_exception(out_exception), .out_timeout(out_timeout), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             is_div;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        int               lat;
        bit               stale;
        logic [31:0]      exp_res;
        logic             exp_exc;
    } vec_t;

    typedef struct {
        logic [31:0]      res;
        logic             exc;
        logic             to;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               acc_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_pulses = 0;
    bit   last_is_div = 1'b0;
    bit   prev_ov = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // multdiv stand-in: RDY mdl_lat cycles after the start pulse, optional early junk RDYs
    int   mdl_lat = 3;
    bit   mdl_stale = 1'b0;
    bit   mdl_never = 1'b0;
    bit   mdl_act = 1'b0;
    int   bcnt = 0;
    logic [31:0] mdl_val = '0;
    logic        mdl_exc = 1'b0;

    always @(negedge clock) begin
        md_resultRDY = 1'b0;
        md_result    = '0;
        md_exception = 1'b0;
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            mdl_act = 1'b1;
            bcnt    = 0;
            mdl_exc = 1'b0;
            if (md_ctrl_DIV) begin
                if (md_operandB == 32'd0) begin
                    mdl_val = '0;
                    mdl_exc = 1'b1;
                end else begin
                    mdl_val = $signed(md_operandA) / $signed(md_operandB);
                end
            end else begin
                mdl_val = $signed(md_operandA) * $signed(md_operandB);
            end
        end else if (mdl_act) begin
            bcnt++;
            if (!mdl_never && bcnt == mdl_lat) begin
                md_resultRDY = 1'b1;
                md_result    = mdl_val;
                md_exception = mdl_exc;
                mdl_act      = 1'b0;
            end else if (mdl_stale && bcnt <= RDY_MASK) begin
                md_resultRDY = 1'b1;
                md_result    = 32'hDEAD_BEEF;
                md_exception = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        #2;
        if (md_ctrl_MULT || md_ctrl_DIV) begin
            n_pulses++;
            chk("ctrl_sel", 64'({md_ctrl_MULT, md_ctrl_DIV}), 64'({!last_is_div, last_is_div}));
        end
        if (out_valid && !prev_ov) begin
            if (sb.size() == 0) chk("unexpected_out_valid", 64'(1), 64'(0));
            else if (sb[0].lat >= 0) chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("result", 64'(out_result), 64'(e.res));
                chk("exception", 64'(out_exception), 64'(e.exc));
                chk("timeout", 64'(out_timeout), 64'(e.to));
                chk("tag", 64'(out_tag), 64'(e.tag));
            end
        end
        prev_ov = out_valid;
    end

    // call at a falling edge; returns at the falling edge after the accepting edge
    task automatic req(input vec_t v, input bit eto);
        bit ok = 1'b0;
        in_valid  = 1'b1;
        in_is_div = v.is_div;
        in_a      = v.a;
        in_b      = v.b;
        in_tag    = v.tag;
        mdl_lat   = v.lat;
        mdl_stale = v.stale;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clock);
                @(negedge clock);
                ok = 1'b1;
                sb.push_back('{res: eto ? 32'd0 : v.exp_res, exc: eto ? 1'b1 : v.exp_exc,
                               to: eto, tag: v.tag, lat: eto ? TIMEOUT + 1 : v.lat + 1,
                               acc_cyc: cyc});
                last_is_div = v.is_div;
                n_acc++;
            end else begin
                @(negedge clock);
            end
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_bound", 64'(0), 64'(1));
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < n && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) chk("drain_bound", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v4, vb2b, vfl, vto, vrst;
        bit   stable, seen;

        tbl[0] = '{is_div: 1'b0, a: 32'd7,         b: 32'hFFFF_FFFA, tag: 5'd3,  lat: 3, stale: 1'b0, exp_res: 32'hFFFF_FFD6, exp_exc: 1'b0};
        tbl[1] = '{is_div: 1'b1, a: 32'd100,       b: 32'd7,         tag: 5'd5,  lat: 5, stale: 1'b0, exp_res: 32'd14,         exp_exc: 1'b0};
        tbl[2] = '{is_div: 1'b1, a: 32'd5,         b: 32'd0,         tag: 5'd6,  lat: 4, stale: 1'b0, exp_res: 32'd0,          exp_exc: 1'b1};
        tbl[3] = '{is_div: 1'b0, a: 32'd123,       b: 32'd456,       tag: 5'd31, lat: 3, stale: 1'b1, exp_res: 32'd56088,      exp_exc: 1'b0};
        tbl[4] = '{is_div: 1'b0, a: 32'hFFFF_FFFD, b: 32'hFFFF_FFFB, tag: 5'd0,  lat: 8, stale: 1'b0, exp_res: 32'd15,         exp_exc: 1'b0};
        tbl[5] = '{is_div: 1'b1, a: 32'hFFFF_FF9C, b: 32'd7,         tag: 5'd9,  lat: 3, stale: 1'b1, exp_res: 32'hFFFF_FFF2, exp_exc: 1'b0};
        v4   = '{is_div: 1'b0, a: 32'd9,  b: 32'd9, tag: 5'd12, lat: 4,  stale: 1'b0, exp_res: 32'd81, exp_exc: 1'b0};
        vb2b = '{is_div: 1'b0, a: 32'd2,  b: 32'd3, tag: 5'd13, lat: 3,  stale: 1'b0, exp_res: 32'd6,  exp_exc: 1'b0};
        vfl  = '{is_div: 1'b1, a: 32'd50, b: 32'd5, tag: 5'd7,  lat: 20, stale: 1'b0, exp_res: 32'd10, exp_exc: 1'b0};
        vto  = '{is_div: 1'b0, a: 32'd1,  b: 32'd1, tag: 5'd21, lat: 5,  stale: 1'b0, exp_res: 32'd1,  exp_exc: 1'b0};
        vrst = '{is_div: 1'b1, a: 32'd9,  b: 32'd3, tag: 5'd2,  lat: 8,  stale: 1'b0, exp_res: 32'd3,  exp_exc: 1'b0};

        reset_n = 1'b0; in_valid = 1'b0; in_is_div = 1'b0; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clock);
        #2;
        chk("rst_ctrl", 64'({out_valid, busy, md_ctrl_MULT, md_ctrl_DIV, out_exception, out_timeout}), 64'(0));
        chk("rst_data", 64'({out_result, out_tag}), 64'(0));
        chk("rst_ops", {md_operandA, md_operandB}, 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            req(tbl[i], 1'b0);
            wait_drain(100);
            #2;
            chk("busy_after", 64'(busy), 64'(0));
            @(negedge clock);
        end

        // hold in DONE with out_ready low, then back-to-back accept
        out_ready = 1'b0;
        req(v4, 1'b0);
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clock);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #2;
            if (out_valid !== 1'b1 || out_result !== 32'd81 || out_tag !== 5'd12 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("hold_stable", 64'(stable), 64'(1));
        chk("hold_in_ready", 64'(in_ready), 64'(0));
        @(negedge clock);
        out_ready = 1'b1;
        req(vb2b, 1'b0);
        #2;
        chk("b2b_start", 64'({md_ctrl_MULT, md_ctrl_DIV, busy}), 64'(3'b101));
        wait_drain(100);
        @(negedge clock);

        // flush in BUSY cycle 5 while a new request is presented
        req(vfl, 1'b0);
        repeat (6) @(negedge clock);
        flush = 1'b1; in_valid = 1'b1; in_is_div = 1'b0; in_a = 32'd4; in_b = 32'd4; in_tag = 5'd1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        #2;
        chk("flush_idle", 64'({busy, out_valid}), 64'(0));
        void'(sb.pop_back());
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            #2;
            if (out_valid || busy) seen = 1'b1;
        end
        chk("flush_quiet", 64'(seen), 64'(0));
        @(negedge clock);
        req(tbl[0], 1'b0);
        wait_drain(100);
        @(negedge clock);

        // watchdog
        mdl_never = 1'b1;
        req(vto, 1'b1);
        wait_drain(100);
        @(negedge clock);

        // reset mid-BUSY; late RDY afterwards must be ignored
        req(vrst, 1'b0);
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        mdl_never = 1'b0;
        @(negedge clock);
        #2;
        chk("midrst_ctrl", 64'({out_valid, busy, md_ctrl_MULT, md_ctrl_DIV, out_exception, out_timeout}), 64'(0));
        chk("midrst_data", 64'({out_result, out_tag}), 64'(0));
        chk("midrst_ops", {md_operandA, md_operandB}, 64'(0));
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            #2;
            if (out_valid || busy) seen = 1'b1;
        end
        chk("midrst_quiet", 64'(seen), 64'(0));
        @(negedge clock);
        req(tbl[1], 1'b0);
        wait_drain(100);

        chk("pulse_count", 64'(n_pulses), 64'(n_acc));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
